// File: rtl/node_reg_slice.sv
// node_reg_slice: fully registered valid/ready pipeline node.
//
// A 2-entry main+skid buffer sits between the upstream and downstream
// handshakes. Every handshake output is decoded from the state register only,
// so the slice breaks the valid, data and ready timing paths and still
// sustains one transfer per cycle.
//
// Ports:
//   clk          clock, all logic on rising edge
//   rst_n        synchronous active-low reset
//   data_in      payload from upstream node
//   up_valid_in  valid from upstream node
//   up_ready_out ready to upstream node (state decode)
//   data_out     payload to downstream node (main_q)
//   dn_valid_out valid to downstream node (state decode)
//   dn_ready_in  ready from downstream node
//   occupancy    entries held: 0, 1 or 2
module node_reg_slice #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             up_valid_in,
    output logic             up_ready_out,
    output logic [WIDTH-1:0] data_out,
    output logic             dn_valid_out,
    input  logic             dn_ready_in,
    output logic [1:0]       occupancy
);

    // State encoding equals the entry count, so occupancy is the state itself.
    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StBusy  = 2'd1;
    localparam logic [1:0] StFull  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             up_fire;
    logic             dn_fire;

    // Output decode: register outputs only, no input-to-output path.
    always_comb begin
        dn_valid_out = (state_q != StEmpty);
        up_ready_out = (state_q != StFull);
        occupancy    = state_q;
        data_out     = main_q;
    end

    assign up_fire = up_valid_in & up_ready_out;
    assign dn_fire = dn_valid_out & dn_ready_in;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            StEmpty: begin
                if (up_fire) begin
                    main_d  = data_in;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (up_fire && dn_fire) begin
                    // Streaming: replace the word being consumed.
                    main_d = data_in;
                end else if (up_fire) begin
                    skid_d  = data_in;
                    state_d = StFull;
                end else if (dn_fire) begin
                    // main_q keeps its stale value; dn_valid_out masks it.
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // up_ready_out is low here, so only the drain side can move.
                if (dn_fire) begin
                    main_d  = skid_q;
                    state_d = StBusy;
                end
            end
            default: begin
                // Unreachable encoding: recover to empty.
                state_d = StEmpty;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_node_reg_slice.sv
// tb_node_reg_slice: directed and random self-checking bench for node_reg_slice.
// Inputs are driven and outputs sampled at the falling edge of clk.
module tb_node_reg_slice;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic        up_valid_in;
    logic        up_ready_out;
    logic [31:0] data_out;
    logic        dn_valid_out;
    logic        dn_ready_in;
    logic [1:0]  occupancy;

    int checks;
    int failures;

    node_reg_slice #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .up_valid_in  (up_valid_in),
        .up_ready_out (up_ready_out),
        .data_out     (data_out),
        .dn_valid_out (dn_valid_out),
        .dn_ready_in  (dn_ready_in),
        .occupancy    (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        up_valid_in = 1'b1;
        data_in     = 32'hDEADBEEF;
        dn_ready_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (dn_valid_out !== 1'b0 || up_ready_out !== 1'b1 || data_out !== 32'h0 ||
                occupancy !== 2'd0) begin
                failures++;
                $display("FAIL reset_edge%0d: got v=%b r=%b d=%h occ=%0d expected v=0 r=1 d=0 occ=0",
                         i, dn_valid_out, up_ready_out, data_out, occupancy);
            end
        end
        up_valid_in = 1'b0;
        rst_n       = 1'b1;
        tick();
        checks++;
        if (dn_valid_out !== 1'b0 || occupancy !== 2'd0 || data_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_release: got v=%b d=%h occ=%0d expected v=0 d=0 occ=0",
                     dn_valid_out, data_out, occupancy);
        end
    endtask

    task automatic test_streaming();
        dn_ready_in = 1'b1;
        up_valid_in = 1'b1;
        data_in     = 32'h1;
        checks++;
        if (dn_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL stream_latency: got v=%b expected 0 before first edge", dn_valid_out);
        end
        for (int i = 1; i <= 8; i++) begin
            data_in = i;
            tick();
            checks++;
            if (dn_valid_out !== 1'b1 || data_out !== i || occupancy !== 2'd1 ||
                up_ready_out !== 1'b1) begin
                failures++;
                $display("FAIL stream_word%0d: got v=%b d=%h occ=%0d r=%b expected v=1 d=%h occ=1 r=1",
                         i, dn_valid_out, data_out, occupancy, up_ready_out, i);
            end
        end
        up_valid_in = 1'b0;
        tick();
        checks++;
        if (dn_valid_out !== 1'b0 || occupancy !== 2'd0) begin
            failures++;
            $display("FAIL stream_empty: got v=%b occ=%0d expected v=0 occ=0",
                     dn_valid_out, occupancy);
        end
    endtask

    task automatic test_backpressure();
        dn_ready_in = 1'b0;
        up_valid_in = 1'b1;
        data_in     = 32'hA;
        tick();
        checks++;
        if (occupancy !== 2'd1 || data_out !== 32'hA || up_ready_out !== 1'b1) begin
            failures++;
            $display("FAIL bp_accept_a: got occ=%0d d=%h r=%b expected occ=1 d=a r=1",
                     occupancy, data_out, up_ready_out);
        end
        data_in = 32'hB;
        tick();
        checks++;
        if (occupancy !== 2'd2 || data_out !== 32'hA || up_ready_out !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept_b: got occ=%0d d=%h r=%b expected occ=2 d=a r=0",
                     occupancy, data_out, up_ready_out);
        end
        data_in = 32'hC;
        tick();
        checks++;
        if (occupancy !== 2'd2 || data_out !== 32'hA || dn_valid_out !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold_c: got occ=%0d d=%h v=%b expected occ=2 d=a v=1",
                     occupancy, data_out, dn_valid_out);
        end
        dn_ready_in = 1'b1;
        checks++;
        if (data_out !== 32'hA || dn_valid_out !== 1'b1) begin
            failures++;
            $display("FAIL bp_drain_a: got d=%h v=%b expected d=a v=1", data_out, dn_valid_out);
        end
        tick();
        checks++;
        if (data_out !== 32'hB || dn_valid_out !== 1'b1 || occupancy !== 2'd1) begin
            failures++;
            $display("FAIL bp_drain_b: got d=%h v=%b occ=%0d expected d=b v=1 occ=1",
                     data_out, dn_valid_out, occupancy);
        end
        tick();
        up_valid_in = 1'b0;
        checks++;
        if (data_out !== 32'hC || dn_valid_out !== 1'b1 || occupancy !== 2'd1) begin
            failures++;
            $display("FAIL bp_drain_c: got d=%h v=%b occ=%0d expected d=c v=1 occ=1",
                     data_out, dn_valid_out, occupancy);
        end
        tick();
        checks++;
        if (dn_valid_out !== 1'b0 || occupancy !== 2'd0) begin
            failures++;
            $display("FAIL bp_empty: got v=%b occ=%0d expected v=0 occ=0", dn_valid_out, occupancy);
        end
    endtask

    task automatic test_full_drain();
        dn_ready_in = 1'b0;
        up_valid_in = 1'b1;
        data_in     = 32'h11;
        tick();
        data_in = 32'h22;
        tick();
        up_valid_in = 1'b0;
        dn_ready_in = 1'b1;
        checks++;
        if (data_out !== 32'h11 || occupancy !== 2'd2) begin
            failures++;
            $display("FAIL drain_c1: got d=%h occ=%0d expected d=11 occ=2", data_out, occupancy);
        end
        tick();
        checks++;
        if (data_out !== 32'h22 || occupancy !== 2'd1 || dn_valid_out !== 1'b1) begin
            failures++;
            $display("FAIL drain_c2: got d=%h occ=%0d v=%b expected d=22 occ=1 v=1",
                     data_out, occupancy, dn_valid_out);
        end
        tick();
        checks++;
        if (occupancy !== 2'd0 || dn_valid_out !== 1'b0 || up_ready_out !== 1'b1) begin
            failures++;
            $display("FAIL drain_c3: got occ=%0d v=%b r=%b expected occ=0 v=0 r=1",
                     occupancy, dn_valid_out, up_ready_out);
        end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] payload;
        logic [31:0] exp_word;
        logic [31:0] prev_data;
        logic        prev_stall;
        logic        up_fire;
        logic        dn_fire;
        payload    = 32'd1000;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (prev_stall) begin
                checks++;
                if (dn_valid_out !== 1'b1 || data_out !== prev_data) begin
                    failures++;
                    $display("FAIL rand_stall cyc%0d: got v=%b d=%h expected v=1 d=%h",
                             cyc, dn_valid_out, data_out, prev_data);
                end
            end
            checks++;
            if (occupancy !== q.size() || up_ready_out !== (occupancy != 2'd2) ||
                dn_valid_out !== (occupancy != 2'd0)) begin
                failures++;
                $display("FAIL rand_state cyc%0d: got occ=%0d r=%b v=%b expected occ=%0d",
                         cyc, occupancy, up_ready_out, dn_valid_out, q.size());
            end
            up_valid_in = 1'($urandom_range(0, 1));
            dn_ready_in = 1'($urandom_range(0, 1));
            data_in     = payload;
            #1;
            up_fire = up_valid_in & up_ready_out;
            dn_fire = dn_valid_out & dn_ready_in;
            if (dn_fire) begin
                exp_word = (q.size() > 0) ? q.pop_front() : 32'hFFFF_FFFF;
                checks++;
                if (data_out !== exp_word) begin
                    failures++;
                    $display("FAIL rand_order cyc%0d: got %h expected %h", cyc, data_out, exp_word);
                end
            end
            if (up_fire) begin
                q.push_back(payload);
                payload++;
            end
            prev_stall = dn_valid_out & ~dn_ready_in;
            prev_data  = data_out;
            tick();
        end
        up_valid_in = 1'b0;
        dn_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (dn_valid_out === 1'b1) begin
                exp_word = (q.size() > 0) ? q.pop_front() : 32'hFFFF_FFFF;
                checks++;
                if (data_out !== exp_word) begin
                    failures++;
                    $display("FAIL rand_drain: got %h expected %h", data_out, exp_word);
                end
            end
            tick();
        end
        checks++;
        if (q.size() != 0 || occupancy !== 2'd0) begin
            failures++;
            $display("FAIL rand_loss: got %0d words left occ=%0d expected 0 occ=0",
                     q.size(), occupancy);
        end
    endtask

    task automatic test_mid_reset();
        dn_ready_in = 1'b0;
        up_valid_in = 1'b1;
        data_in     = 32'h33;
        tick();
        data_in = 32'h44;
        tick();
        checks++;
        if (occupancy !== 2'd2) begin
            failures++;
            $display("FAIL mrst_fill: got occ=%0d expected 2", occupancy);
        end
        up_valid_in = 1'b0;
        rst_n       = 1'b0;
        tick();
        checks++;
        if (occupancy !== 2'd0 || dn_valid_out !== 1'b0 || data_out !== 32'h0 ||
            up_ready_out !== 1'b1) begin
            failures++;
            $display("FAIL mrst_clear: got occ=%0d v=%b d=%h r=%b expected occ=0 v=0 d=0 r=1",
                     occupancy, dn_valid_out, data_out, up_ready_out);
        end
        rst_n       = 1'b1;
        up_valid_in = 1'b1;
        data_in     = 32'h55;
        tick();
        up_valid_in = 1'b0;
        checks++;
        if (dn_valid_out !== 1'b1 || data_out !== 32'h55 || occupancy !== 2'd1) begin
            failures++;
            $display("FAIL mrst_next: got v=%b d=%h occ=%0d expected v=1 d=55 occ=1",
                     dn_valid_out, data_out, occupancy);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        up_valid_in = 1'b0;
        dn_ready_in = 1'b0;
        data_in     = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_full_drain();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
